dmem_arbiter: RTL

//  Two-requester round-robin arbiter/sequencer in front of the single-port data memory (256 x 32).

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter/sequencer between two requesters and a single-port
//   data memory. Each winning command is registered, issued to memory for one
//   cycle, and (for reads) answered one cycle later with an rvalid pulse.
//   Out-of-range addresses are never forwarded to memory and are flagged.
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   pN_req/we/addr/wdata  request from port N (0 = MEM stage, 1 = loader/debug)
//   pN_gnt                pulse: command issued to memory this cycle
//   pN_err                pulse with gnt: address out of range
//   pN_rvalid/pN_rdata    read response pulse / data held until next response
//   mem_write/mem_read    memory strobes (only during issue)
//   mem_address/_write_data  memory address / write data
//   mem_read_data         combinational memory read data
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t            r_state, w_next;
  logic              r_last;   // port granted most recently
  logic              r_port;   // port owning the current command
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_p0_rdata, r_p1_rdata;

  logic              w_sel_p1;
  logic              w_in_range;
  logic [DATA_W-1:0] w_rd_capture;

  // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
  assign w_sel_p1     = p1_req && (!p0_req || !r_last);
  assign w_in_range   = (r_addr < ADDR_W'(DEPTH));
  assign w_rd_capture = w_in_range ? mem_read_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last     <= 1'b1;
      r_port     <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && (p0_req || p1_req)) begin
        r_port  <= w_sel_p1;
        r_last  <= w_sel_p1;
        r_we    <= w_sel_p1 ? p1_we    : p0_we;
        r_addr  <= w_sel_p1 ? p1_addr  : p0_addr;
        r_wdata <= w_sel_p1 ? p1_wdata : p0_wdata;
      end
      if (r_state == S_ISSUE && !r_we) begin
        if (r_port) begin
          r_p1_rdata <= w_rd_capture;
        end else begin
          r_p0_rdata <= w_rd_capture;
        end
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    p0_gnt         = 1'b0;
    p1_gnt         = 1'b0;
    p0_err         = 1'b0;
    p1_err         = 1'b0;
    p0_rvalid      = 1'b0;
    p1_rvalid      = 1'b0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    unique case (r_state)
      S_IDLE: begin
        if (p0_req || p1_req) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        p0_gnt         = !r_port;
        p1_gnt         = r_port;
        p0_err         = !r_port && !w_in_range;
        p1_err         = r_port && !w_in_range;
        mem_address    = r_addr;
        mem_write_data = r_wdata;
        mem_write      = r_we && w_in_range;
        mem_read       = !r_we && w_in_range;
        w_next         = r_we ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        p0_rvalid = !r_port;
        p1_rvalid = r_port;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign p0_rdata = r_p0_rdata;
  assign p1_rdata = r_p1_rdata;

endmodule
